instr_mem_fetch: RTL and testbench

Parametrised instruction store with a built-in program counter and registered fetch. It replaces purely combinational field slicing with a loadable memory array, a run/halt sequencer, stall and jump handling, and a registered decode of the Addr1/Addr2/Control/Word fields. It sits at the front of the datapath and feeds the register-file read addresses and the control decoder.

---
 rtl/instr_mem_fetch_if.sv | 63 ++++++
 rtl/instr_mem_fetch.sv | 192 +++++++++++++++++++
 tb/tb_instr_mem_fetch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch_if
//   Bundle of the program-load, sequencing and decoded-fetch signals of
//   instr_mem_fetch. clk and rst stay plain ports on the module.
//
//   master : the controller side (loads memory, starts/stalls/jumps, consumes
//            the decoded fields)
//   slave  : the fetch unit itself
//
//   Signals
//     wr_en / wr_addr / wr_data   program memory write port
//     start / start_addr          begin fetching at start_addr
//     stall                       freeze fetch and outputs
//     jump_en / jump_addr         redirect the PC
//     Addr1 / Addr2 / Control / Word   registered instruction fields
//     pc_out                      address of the instruction on the outputs
//     valid                       outputs hold a newly fetched instruction
//     halted                      fetch unit is in HALT
//     parity_err                  only when IMEM_PARITY_EN is defined
// -----------------------------------------------------------------------------
interface instr_mem_fetch_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int REG_W   = 4,
  parameter int CTRL_W  = 4,
  parameter int WORD_W  = 8
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               stall;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  logic [REG_W-1:0]   Addr1;
  logic [REG_W-1:0]   Addr2;
  logic [CTRL_W-1:0]  Control;
  logic [WORD_W-1:0]  Word;
  logic [ADDR_W-1:0]  pc_out;
  logic               valid;
  logic               halted;
`ifdef IMEM_PARITY_EN
  logic               parity_err;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, start, start_addr, stall, jump_en, jump_addr,
    input  Addr1, Addr2, Control, Word, pc_out, valid, halted
`ifdef IMEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_addr, stall, jump_en, jump_addr,
    output Addr1, Addr2, Control, Word, pc_out, valid, halted
`ifdef IMEM_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
//   Instruction store with a program counter, a run/halt sequencer and a
//   registered decode of the Addr1 / Addr2 / Control / Word fields.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (memory contents are kept)
//     bus  : instr_mem_fetch_if.slave (write port, start/stall/jump controls,
//            decoded fields, pc_out, valid, halted)
//
//   Optional build macro
//     IMEM_PARITY_EN : store an even-parity bit per word, present parity_err
//                      with each fetch and halt on a parity mismatch.
//
//   Timing: pc -> outputs is one cycle. An instruction whose Control equals
//   HALT_OP (or that fails parity) is shown with valid=1; the first unstalled
//   edge after that enters HALT, drops valid and stops fetching.
// -----------------------------------------------------------------------------
module instr_mem_fetch #(
  parameter int               ADDR_W  = 4,
  parameter int               INSTR_W = 16,
  parameter int               REG_W   = 4,
  parameter int               CTRL_W  = 4,
  parameter int               WORD_W  = 8,
  parameter logic [CTRL_W-1:0] HALT_OP = CTRL_W'(4'hF)
) (
  input logic              clk,
  input logic              rst,
  instr_mem_fetch_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [INSTR_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_out;
  logic [REG_W-1:0]   r_addr1;
  logic [REG_W-1:0]   r_addr2;
  logic [CTRL_W-1:0]  r_control;
  logic [WORD_W-1:0]  r_word;
  logic               r_valid;

  logic [INSTR_W-1:0] w_rd_instr;
  logic               w_stop;        // instruction on the outputs ends the run
  logic               w_load_start;  // load pc from start_addr
  logic               w_fetch;       // register mem[pc] and advance pc
  logic               w_drop_valid;  // leaving RUN: no fetch, valid falls
  logic               w_jump_only;   // stalled: only the pc follows a jump

  // Read-first: this asynchronous read sees the array before any write
  // committed on the same edge.
  assign w_rd_instr = r_mem[r_pc];

  // Bits above the decoded fields are not used by the decode itself.
  logic w_unused_hi;
  assign w_unused_hi = ^w_rd_instr;

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;
  logic w_rd_perr;

  // Stored even-parity bit versus parity recomputed from the fetched word.
  assign w_rd_perr = r_par[r_pc] ^ (^w_rd_instr);
  assign w_stop    = r_valid && ((r_control == HALT_OP) || r_parity_err);
`else
  assign w_stop    = r_valid && (r_control == HALT_OP);
`endif

  // ---------------------------------------------------------------------------
  // Program memory: written in every state, including during rst.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch on purpose; rst must not erase the
    // loaded program, and a resettable array could not map onto RAM.
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
`ifdef IMEM_PARITY_EN
      r_par[bus.wr_addr] <= ^bus.wr_data;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge value of every other register, independent of block order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default first means no path leaves w_state_nxt
    // unassigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (bus.start) w_state_nxt = S_RUN;
      S_RUN:          if (!bus.start && !bus.stall && w_stop) w_state_nxt = S_HALT;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output (datapath control) logic
  // start beats stall and jump; stall beats the halt decision, so a halting
  // instruction stays presented until stall drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load_start = 1'b0;
    w_fetch      = 1'b0;
    w_drop_valid = 1'b0;
    w_jump_only  = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: w_load_start = bus.start;
      S_RUN: begin
        if (bus.start)      w_load_start = 1'b1;
        else if (bus.stall) w_jump_only  = bus.jump_en;
        else if (w_stop)    w_drop_valid = 1'b1;
        else                w_fetch      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: program counter and registered fetch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_pc_out  <= '0;
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_control <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
`ifdef IMEM_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else if (w_load_start) begin
      r_pc    <= bus.start_addr;
      r_valid <= 1'b0;
    end else if (w_fetch) begin
      r_addr1   <= w_rd_instr[2*REG_W+CTRL_W-1 -: REG_W];
      r_addr2   <= w_rd_instr[REG_W+CTRL_W-1   -: REG_W];
      r_control <= w_rd_instr[CTRL_W-1:0];
      r_word    <= w_rd_instr[WORD_W-1:0];
      r_pc_out  <= r_pc;
      r_valid   <= 1'b1;
`ifdef IMEM_PARITY_EN
      r_parity_err <= w_rd_perr;
`endif
      // Jump wins over increment; the increment wraps at the address width.
      r_pc <= bus.jump_en ? bus.jump_addr : r_pc + ADDR_W'(1);
    end else if (w_drop_valid) begin
      r_valid <= 1'b0;
    end else if (w_jump_only) begin
      r_pc <= bus.jump_addr;
    end
  end

  assign bus.Addr1   = r_addr1;
  assign bus.Addr2   = r_addr2;
  assign bus.Control = r_control;
  assign bus.Word    = r_word;
  assign bus.pc_out  = r_pc_out;
  assign bus.valid   = r_valid;
  assign bus.halted  = (r_state == S_HALT);
`ifdef IMEM_PARITY_EN
  assign bus.parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
//   Directed scenarios followed by a randomized run. Expected outputs come
//   from a behavioural model: a word array plus "shown instruction" and
//   "next fetch address" bookkeeping, with fields extracted by arithmetic.
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;
  localparam int REG_W   = 4;
  localparam int CTRL_W  = 4;
  localparam int WORD_W  = 8;
  localparam int HALT_OP = 'hF;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_mem_fetch_if #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .REG_W(REG_W),
    .CTRL_W(CTRL_W), .WORD_W(WORD_W)
  ) bus ();

  instr_mem_fetch #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .REG_W(REG_W),
    .CTRL_W(CTRL_W), .WORD_W(WORD_W), .HALT_OP(CTRL_W'(HALT_OP))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  int model_mem [DEPTH];
  bit corrupt   [DEPTH];
  bit m_run, m_halted, m_valid, m_perr;
  int m_word, m_addr, m_next;

  function automatic int f_a1(input int w);
    return (w >> (REG_W + CTRL_W)) % (1 << REG_W);
  endfunction
  function automatic int f_a2(input int w);
    return (w >> CTRL_W) % (1 << REG_W);
  endfunction
  function automatic int f_ct(input int w);
    return w % (1 << CTRL_W);
  endfunction
  function automatic int f_wd(input int w);
    return w % (1 << WORD_W);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs for one clock edge, advance the model, then
  // compare every output 1 time unit after the edge.
  task automatic cycle(input string tag);
    bit loose;
    loose = 1'b0;
    if (rst) begin
      m_run = 0; m_halted = 0; m_valid = 0; m_perr = 0;
      m_word = 0; m_addr = 0; m_next = 0;
    end else if (bus.start) begin
      // A restart while running: only the next fetch address is pinned down.
      if (m_run) begin loose = 1'b1; m_valid = 0; end
      m_run = 1; m_halted = 0; m_next = int'(bus.start_addr);
    end else if (m_run) begin
      if (!bus.stall) begin
        if (m_valid && (f_ct(m_word) == HALT_OP || m_perr)) begin
          m_run = 0; m_halted = 1; m_valid = 0;
        end else begin
          m_word  = model_mem[m_next];
          m_perr  = corrupt[m_next];
          m_addr  = m_next;
          m_valid = 1;
          m_next  = bus.jump_en ? int'(bus.jump_addr) : (m_next + 1) % DEPTH;
        end
      end else if (bus.jump_en) begin
        m_next = int'(bus.jump_addr);
      end
    end
    // Writes land after the read of the same edge.
    if (bus.wr_en) begin
      model_mem[bus.wr_addr] = int'(bus.wr_data);
      corrupt[bus.wr_addr]   = 1'b0;
    end

    @(posedge clk);
    #1;

    check({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
    if (!loose) begin
      check({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
      check({tag, ".pc_out"},  32'(bus.pc_out),  32'(m_addr));
      check({tag, ".Addr1"},   32'(bus.Addr1),   32'(f_a1(m_word)));
      check({tag, ".Addr2"},   32'(bus.Addr2),   32'(f_a2(m_word)));
      check({tag, ".Control"}, 32'(bus.Control), 32'(f_ct(m_word)));
      check({tag, ".Word"},    32'(bus.Word),    32'(f_wd(m_word)));
`ifdef IMEM_PARITY_EN
      if (m_valid) check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(m_perr));
`endif
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 0; bus.start_addr = '0;
    bus.stall = 0; bus.jump_en = 0; bus.jump_addr = '0;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
    cycle("wr");
    bus.wr_en = 0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    bus.start = 1; bus.start_addr = a;
    cycle("start");
    bus.start = 0;
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 20 && !m_halted; i++) cycle(tag);
    check({tag, ".reached_halt"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
    idle_inputs();

    // Reset, clearing the program through the write port while rst is high.
    rst = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1; bus.wr_addr = ADDR_W'(i); bus.wr_data = '0;
      cycle("reset");
    end
    idle_inputs();
    cycle("reset");
    check("reset.valid0",  32'(bus.valid),   32'd0);
    check("reset.pc_out0", 32'(bus.pc_out),  32'd0);
    rst = 0;

    // Basic run to a HALT_OP.
    write_word(0, 16'h0123);
    write_word(1, 16'h0456);
    write_word(2, 16'h0789);
    write_word(3, 16'h000F);
    do_start(0);
    cycle("t1"); check("t1.ctl0", 32'(bus.Control), 32'h3); check("t1.pc0", 32'(bus.pc_out), 32'd0);
    cycle("t1"); check("t1.ctl1", 32'(bus.Control), 32'h6); check("t1.pc1", 32'(bus.pc_out), 32'd1);
    cycle("t1"); check("t1.ctl2", 32'(bus.Control), 32'h9); check("t1.pc2", 32'(bus.pc_out), 32'd2);
    cycle("t1"); check("t1.ctl3", 32'(bus.Control), 32'hF); check("t1.val3", 32'(bus.valid), 32'd1);
    check("t1.nohalt_yet", 32'(bus.halted), 32'd0);
    cycle("t1"); check("t1.valid_off", 32'(bus.valid), 32'd0); check("t1.halted", 32'(bus.halted), 32'd1);
    cycle("t1_hold");

    // Field decode.
    write_word(0, 16'h0A5C);
    do_start(0);
    cycle("t2");
    check("t2.Addr1", 32'(bus.Addr1), 32'hA);
    check("t2.Addr2", 32'(bus.Addr2), 32'h5);
    check("t2.Ctrl",  32'(bus.Control), 32'hC);
    check("t2.Word",  32'(bus.Word), 32'h5C);
    run_to_halt("t2");

    // PC wrap from all-ones to zero.
    write_word(4'hE, 16'h0001);
    write_word(4'hF, 16'h0002);
    write_word(4'h0, 16'h000F);
    do_start(4'hE);
    cycle("t3"); check("t3.pcE", 32'(bus.pc_out), 32'hE);
    cycle("t3"); check("t3.pcF", 32'(bus.pc_out), 32'hF);
    cycle("t3"); check("t3.pc0", 32'(bus.pc_out), 32'h0);
    cycle("t3"); check("t3.halted", 32'(bus.halted), 32'd1);

    // Stall with a jump issued during the stall; stall over a HALT_OP.
    write_word(4, 16'h0456);
    write_word(5, 16'h0789);
    write_word(8, 16'h1238);
    write_word(9, 16'h000F);
    do_start(4);
    cycle("t4");
    bus.stall = 1; bus.jump_en = 1; bus.jump_addr = 8;
    cycle("t4s"); check("t4s.pc_frozen0", 32'(bus.pc_out), 32'd4);
    bus.jump_en = 0;
    cycle("t4s"); check("t4s.ctl_frozen1", 32'(bus.Control), 32'h6);
    cycle("t4s"); check("t4s.pc_frozen2", 32'(bus.pc_out), 32'd4);
    bus.stall = 0;
    cycle("t4"); check("t4.jumped", 32'(bus.pc_out), 32'd8);
    cycle("t4"); check("t4.halt_shown", 32'(bus.Control), 32'hF);
    bus.stall = 1;
    cycle("t4h"); check("t4h.still_valid", 32'(bus.valid), 32'd1);
    cycle("t4h"); check("t4h.not_halted", 32'(bus.halted), 32'd0);
    bus.stall = 0;
    cycle("t4h"); check("t4h.halted", 32'(bus.halted), 32'd1);

    // Reset mid-run with a write, start and jump all asserted.
    write_word(10, 16'h0111);
    write_word(11, 16'h0222);
    write_word(12, 16'h000F);
    do_start(10);
    cycle("t5");
    cycle("t5");
    rst = 1; bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 16'h0333;
    bus.start = 1; bus.start_addr = 5; bus.jump_en = 1; bus.jump_addr = 7;
    cycle("t5r");
    check("t5r.valid", 32'(bus.valid), 32'd0);
    check("t5r.ctl",   32'(bus.Control), 32'd0);
    check("t5r.pc",    32'(bus.pc_out), 32'd0);
    rst = 0;
    idle_inputs();
    // IDLE ignores stall and jump.
    bus.stall = 1; bus.jump_en = 1; bus.jump_addr = 7;
    cycle("t5i"); check("t5i.valid", 32'(bus.valid), 32'd0);
    idle_inputs();
    do_start(2);
    cycle("t5f");
    check("t5f.Addr1", 32'(bus.Addr1), 32'h3);
    check("t5f.Addr2", 32'(bus.Addr2), 32'h3);
    check("t5f.Word",  32'(bus.Word), 32'h33);
    run_to_halt("t5f");

    // start while running overrides a simultaneous jump.
    do_start(10);
    cycle("t6");
    bus.start = 1; bus.start_addr = 12; bus.jump_en = 1; bus.jump_addr = 5;
    cycle("t6s");
    idle_inputs();
    cycle("t6"); check("t6.pc_restart", 32'(bus.pc_out), 32'd12);
    run_to_halt("t6");

`ifdef IMEM_PARITY_EN
    // Corrupt a stored word behind the write port.
    write_word(6, 16'h0123);
    write_word(7, 16'h000F);
    dut.r_mem[6] = dut.r_mem[6] ^ 16'h0010;
    model_mem[6] = model_mem[6] ^ 'h0010;
    corrupt[6]   = 1'b1;
    do_start(6);
    cycle("tp"); check("tp.perr", 32'(bus.parity_err), 32'd1); check("tp.valid", 32'(bus.valid), 32'd1);
    cycle("tp"); check("tp.halted", 32'(bus.halted), 32'd1);
`endif

    // Randomized program and control traffic.
    for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), INSTR_W'($urandom_range(16'hFFFF)));
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(39) == 0);
      bus.start      = !m_run && ($urandom_range(2) == 0);
      bus.start_addr = ADDR_W'($urandom_range(DEPTH - 1));
      bus.stall      = ($urandom_range(3) == 0);
      bus.jump_en    = ($urandom_range(5) == 0);
      bus.jump_addr  = ADDR_W'($urandom_range(DEPTH - 1));
      bus.wr_en      = ($urandom_range(4) == 0);
      bus.wr_addr    = ADDR_W'($urandom_range(DEPTH - 1));
      bus.wr_data    = INSTR_W'($urandom_range(16'hFFFF));
      cycle("rnd");
    end
    rst = 0;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
